open_fifo_mwnr_flopped: RTL and testbench

//  Multi-write / multi-read in-order FIFO with a fully flopped storage array and an "open" view of every slot.

---
 rtl/open_fifo_mwnr_flopped.sv | 135 +++++++++++++
 tb/tb_open_fifo_mwnr_flopped.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/open_fifo_mwnr_flopped.sv
// Multi-write / multi-read in-order FIFO with flopped storage and an open view of every slot.
// Accepts up to NW contiguous pushes and serves up to NR contiguous pops per cycle.
module open_fifo_mwnr_flopped #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 16,
    parameter int NW       = 2,
    parameter int NR       = 2,
    parameter int AFULL_TH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NW-1:0]                push,
    input  logic [NW*DWIDTH-1:0]         push_data,
    output logic                         push_accept,
    input  logic [NR-1:0]                pop,
    output logic [NR*DWIDTH-1:0]         pop_data,
    output logic [NR-1:0]                pop_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [DEPTH*DWIDTH-1:0]      open_data,
    output logic [DEPTH-1:0]             open_valid,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic                         err_ovf,
    output logic                         err_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;

    logic [CW-1:0] npush;
    logic [CW-1:0] npop;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] add_n;
    logic [CW-1:0] sub_n;
    logic [CW-1:0] count_nxt;
    logic          push_therm;
    logic          pop_therm;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [CW-1:0] ones_w(input logic [NW-1:0] m);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NW; i++) n = n + CW'(m[i]);
        return n;
    endfunction

    function automatic logic [CW-1:0] ones_r(input logic [NR-1:0] m);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NR; i++) n = n + CW'(m[i]);
        return n;
    endfunction

    function automatic logic therm_w(input logic [NW-1:0] m);
        for (int i = 1; i < NW; i++)
            if (m[i] && !m[i-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic therm_r(input logic [NR-1:0] m);
        for (int i = 1; i < NR; i++)
            if (m[i] && !m[i-1]) return 1'b0;
        return 1'b1;
    endfunction

    // Admission uses the pre-pop occupancy: same-cycle pops never make room.
    always_comb begin
        npush      = ones_w(push);
        npop       = ones_r(pop);
        push_therm = therm_w(push);
        pop_therm  = therm_r(pop);
        free_slots = DEPTH_C - count;
        push_ok    = push_therm && (npush <= free_slots);
        pop_ok     = pop_therm && (npop <= count);
        add_n      = push_ok ? npush : '0;
        sub_n      = pop_ok ? npop : '0;
        count_nxt  = count + add_n - sub_n;
    end

    assign push_accept = push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(npush);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(npop);
            count <= count_nxt;
            if ((|push) && !push_ok)      err_ovf <= 1'b1;
            if (!pop_ok || !push_therm)   err_udf <= 1'b1;
        end
    end

    // Storage is data-only: never reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            for (int i = 0; i < NW; i++)
                if (push[i]) mem[wr_ptr + AW'(i)] <= push_data[i*DWIDTH +: DWIDTH];
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_pop
        assign pop_data[g*DWIDTH +: DWIDTH] = mem[rd_ptr + AW'(g)];
        assign pop_valid[g]                 = count > CW'(g);
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_open
        logic [AW-1:0] off;
        assign off                           = AW'(j) - rd_ptr;
        assign open_valid[j]                 = CW'(off) < count;
        assign open_data[j*DWIDTH +: DWIDTH] = mem[j];
    end

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (free_slots < AFULL_C);

endmodule

// File: tb/tb_open_fifo_mwnr_flopped.sv
// Directed bench for open_fifo_mwnr_flopped: fill, overflow, wrap, underflow, flush and reset.
module tb_open_fifo_mwnr_flopped;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        push;
    logic [2*DW-1:0]   push_data;
    logic              push_accept;
    logic [1:0]        pop;
    logic [2*DW-1:0]   pop_data;
    logic [1:0]        pop_valid;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [DEPTH*DW-1:0] open_data;
    logic [DEPTH-1:0]  open_valid;
    logic [3:0]        rd_ptr;
    logic              err_ovf;
    logic              err_udf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    open_fifo_mwnr_flopped #(
        .DWIDTH(DW), .DEPTH(DEPTH), .NW(2), .NR(2), .AFULL_TH(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push), .push_data(push_data), .push_accept(push_accept),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .open_data(open_data), .open_valid(open_valid), .rd_ptr(rd_ptr),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] p, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] q, input logic f);
        push      = p;
        push_data = {d1, d0};
        pop       = q;
        flush     = f;
        @(posedge clk);
        #1;
        push  = '0;
        pop   = '0;
        flush = 1'b0;
    endtask

    logic [31:0] mq[$];
    logic [31:0] v;
    logic [15:0] m;
    int          mrd;

    initial begin
        rst = 1'b1; flush = 1'b0; push = '0; pop = '0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovalid", open_valid, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_udf", err_udf, 0);
        chk("rst_rdptr", rd_ptr, 0);
        chk("rst_accept", push_accept, 1);

        step(2'b11, 32'hA0, 32'hB1, 2'b00, 1'b0);
        chk("p1_count", count, 2);
        chk("p1_d0", pop_data[31:0], 32'hA0);
        chk("p1_d1", pop_data[63:32], 32'hB1);
        chk("p1_pvalid", pop_valid, 2'b11);
        chk("p1_rdptr", rd_ptr, 0);
        chk("p1_ovalid", open_valid, 16'h0003);

        for (int k = 1; k < 8; k++) begin
            step(2'b11, 32'h100 + 2*k, 32'h101 + 2*k, 2'b00, 1'b0);
            if (k == 6) chk("af_at14", almost_full, 0);
        end
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_af", almost_full, 1);
        chk("fill_ovalid", open_valid, 16'hFFFF);

        push = 2'b01; push_data = {32'h0, 32'hCC};
        #1;
        chk("ovf_accept", push_accept, 0);
        @(posedge clk); #1;
        push = '0;
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_count", count, 16);
        chk("ovf_udf", err_udf, 0);

        step(2'b00, 0, 0, 2'b01, 1'b0);
        chk("c15_count", count, 15);
        chk("c15_rdptr", rd_ptr, 1);
        chk("c15_d0", pop_data[31:0], 32'hB1);
        chk("c15_af", almost_full, 1);
        chk("c15_full", full, 0);

        push = 2'b11; push_data = {32'hDEAD0001, 32'hDEAD0000}; pop = 2'b01;
        #1;
        chk("prepop_accept", push_accept, 0);
        @(posedge clk); #1;
        push = '0; pop = '0;
        chk("prepop_count", count, 14);
        chk("prepop_rdptr", rd_ptr, 2);
        chk("prepop_slot0", open_data[31:0], 32'hA0);
        chk("prepop_d0", pop_data[31:0], 32'h102);

        repeat (5) step(2'b00, 0, 0, 2'b11, 1'b0);
        chk("dr_count", count, 4);
        chk("dr_rdptr", rd_ptr, 12);
        chk("dr_d0", pop_data[31:0], 32'h10C);
        chk("dr_d1", pop_data[63:32], 32'h10D);

        mq = '{32'h10C, 32'h10D, 32'h10E, 32'h10F};
        mrd = 12;
        v = 32'h200;
        for (int c = 0; c < 20; c++) begin
            step(2'b11, v, v + 1, 2'b11, 1'b0);
            mq.push_back(v);
            mq.push_back(v + 1);
            void'(mq.pop_front());
            void'(mq.pop_front());
            v = v + 2;
            mrd = (mrd + 2) % DEPTH;
            m = '0;
            for (int k = 0; k < 4; k++) m[(mrd + k) % DEPTH] = 1'b1;
            chk("wrap_rdptr", rd_ptr, mrd);
            chk("wrap_count", count, 4);
            chk("wrap_d0", pop_data[31:0], mq[0]);
            chk("wrap_d1", pop_data[63:32], mq[1]);
            chk("wrap_ovalid", open_valid, m);
        end

        step(2'b00, 0, 0, 2'b11, 1'b0);
        step(2'b00, 0, 0, 2'b01, 1'b0);
        void'(mq.pop_front()); void'(mq.pop_front()); void'(mq.pop_front());
        chk("c1_count", count, 1);
        chk("c1_rdptr", rd_ptr, 7);
        chk("c1_pvalid", pop_valid, 2'b01);
        chk("c1_d0", pop_data[31:0], mq[0]);
        chk("c1_udf_pre", err_udf, 0);

        step(2'b00, 0, 0, 2'b11, 1'b0);
        chk("udf_flag", err_udf, 1);
        chk("udf_count", count, 1);
        chk("udf_rdptr", rd_ptr, 7);
        chk("udf_d0", pop_data[31:0], mq[0]);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_udf", err_udf, 0);
        chk("rst2_ovf", err_ovf, 0);
        chk("rst2_count", count, 0);

        step(2'b11, 32'h300, 32'h301, 2'b00, 1'b0);
        step(2'b00, 0, 0, 2'b10, 1'b0);
        chk("nt_udf", err_udf, 1);
        chk("nt_count", count, 2);
        chk("nt_rdptr", rd_ptr, 0);
        chk("nt_d0", pop_data[31:0], 32'h300);

        step(2'b11, 32'h302, 32'h303, 2'b00, 1'b0);
        step(2'b01, 32'h304, 32'h0, 2'b00, 1'b0);
        chk("pf_count", count, 5);
        step(2'b11, 32'h400, 32'h401, 2'b00, 1'b1);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_ovalid", open_valid, 0);
        chk("fl_rdptr", rd_ptr, 0);
        chk("fl_pvalid", pop_valid, 0);
        chk("fl_udf", err_udf, 1);
        chk("fl_ovf", err_ovf, 0);

        step(2'b11, 32'h500, 32'h501, 2'b00, 1'b0);
        chk("pfl_count", count, 2);
        chk("pfl_d0", pop_data[31:0], 32'h500);
        chk("pfl_d1", pop_data[63:32], 32'h501);
        chk("pfl_slot0", open_data[31:0], 32'h500);

        step(2'b11, 32'h600, 32'h601, 2'b00, 1'b0);
        chk("mf_count", count, 4);
        rst = 1'b1; push = 2'b11; push_data = {32'h701, 32'h700};
        @(posedge clk); #1;
        rst = 1'b0; push = '0;
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_full", full, 0);
        chk("mr_af", almost_full, 0);
        chk("mr_udf", err_udf, 0);
        chk("mr_ovf", err_ovf, 0);
        chk("mr_ovalid", open_valid, 0);
        chk("mr_rdptr", rd_ptr, 0);
        chk("mr_pvalid", pop_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
